// File: rtl/codec_cfg_pkg.sv
// Shared types, codec register map and the power-up init table for the codec
// configuration sequencer.
package codec_cfg_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StPwrup,
        StLoad,
        StIssue,
        StWait,
        StCheck,
        StGap,
        StDone,
        StError
    } state_e;

    // Codec register addresses (7-bit)
    localparam logic [6:0] R_LLINE  = 7'd0;
    localparam logic [6:0] R_RLINE  = 7'd1;
    localparam logic [6:0] R_LHP    = 7'd2;
    localparam logic [6:0] R_RHP    = 7'd3;
    localparam logic [6:0] R_APATH  = 7'd4;
    localparam logic [6:0] R_DPATH  = 7'd5;
    localparam logic [6:0] R_PWR    = 7'd6;
    localparam logic [6:0] R_IFACE  = 7'd7;
    localparam logic [6:0] R_SRATE  = 7'd8;
    localparam logic [6:0] R_ACTIVE = 7'd9;
    localparam logic [6:0] R_RESET  = 7'd15;

    // Init table entry idx as a {reg_addr, reg_data} word
    function automatic logic [15:0] init_word(input logic [3:0] idx);
        case (idx)
            4'd0:    init_word = {R_RESET,  9'h000};
            4'd1:    init_word = {R_LLINE,  9'h017};
            4'd2:    init_word = {R_RLINE,  9'h017};
            4'd3:    init_word = {R_LHP,    9'h079};
            4'd4:    init_word = {R_RHP,    9'h079};
            4'd5:    init_word = {R_APATH,  9'h012};
            4'd6:    init_word = {R_DPATH,  9'h000};
            4'd7:    init_word = {R_PWR,    9'h000};
            4'd8:    init_word = {R_IFACE,  9'h042};
            4'd9:    init_word = {R_SRATE,  9'h000};
            4'd10:   init_word = {R_ACTIVE, 9'h001};
            default: init_word = 16'h0000;
        endcase
    endfunction

    // Headphone volume: both channels, no zero-cross detect
    function automatic logic [15:0] vol_word(input logic [6:0] level);
        vol_word = {R_LHP, 1'b1, 1'b0, level};
    endfunction

endpackage

// File: rtl/codec_config_sequencer_timer.sv
// Loadable down-counter with a zero flag; times both the power-up wait and the
// inter-word gap. Counter parks at zero.
module codec_cfg_timer #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Reload while idle, otherwise count down to zero and hold
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= WIDTH'(RESET_VAL);
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/codec_config_sequencer.sv
// Sole master of the codec I2C word writer: replays the init table after
// power-up, then services headphone-volume writes, with ACK retry and error
// reporting.
module codec_config_sequencer
    import codec_cfg_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 50_000_000,
    parameter int unsigned POWERUP_CYCLES = CLK_HZ / 1000,
    parameter int unsigned GAP_CYCLES     = CLK_HZ / 25_000,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned NUM_REGS       = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        vol_req,
    input  logic [6:0]  vol_level,
    output logic [15:0] wr_word,
    output logic        wr_go,
    input  logic        wr_done,
    input  logic [2:0]  wr_ack,
    output logic        busy,
    output logic        config_done,
    output logic        error,
    output logic [3:0]  err_index
);

    localparam int unsigned MaxCycles =
        (POWERUP_CYCLES > GAP_CYCLES) ? POWERUP_CYCLES : GAP_CYCLES;
    localparam int unsigned TimerW = $clog2(MaxCycles) + 1;
    localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    // Loaded with N-1 so the timed state lasts exactly N cycles
    localparam logic [TimerW-1:0] PwrupLoad = TimerW'(POWERUP_CYCLES - 1);
    localparam logic [TimerW-1:0] GapLoad   = TimerW'(GAP_CYCLES - 1);
    localparam logic [RetryW-1:0] MaxRetry  = RetryW'(MAX_RETRY);
    localparam logic [3:0]        LastIdx   = 4'(NUM_REGS - 1);

    state_e             state;
    logic [3:0]         idx;
    logic [RetryW-1:0]  retry;
    logic               retrying;
    logic               is_vol;
    logic               vol_pending;
    logic [6:0]         vol_level_q;
    logic [2:0]         ack_q;
    logic               timer_load;
    logic               timer_zero;
    logic [TimerW-1:0]  timer_val;

    // Timer is held at its preload outside the two timed states
    always_comb begin
        timer_load = (state != StPwrup) && (state != StGap);
        timer_val  = (state == StCheck) ? GapLoad : PwrupLoad;
    end

    codec_cfg_timer #(
        .WIDTH     (TimerW),
        .RESET_VAL (POWERUP_CYCLES - 1)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (timer_zero)
    );

    // Sequencer FSM with registered writer and status outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= StPwrup;
            wr_word     <= '0;
            wr_go       <= 1'b0;
            busy        <= 1'b0;
            config_done <= 1'b0;
            error       <= 1'b0;
            err_index   <= '0;
            idx         <= '0;
            retry       <= '0;
            retrying    <= 1'b0;
            is_vol      <= 1'b0;
            vol_pending <= 1'b0;
            vol_level_q <= '0;
            ack_q       <= '0;
        end else begin
            busy <= 1'b1;
            case (state)
                StPwrup: begin
                    if (timer_zero) begin
                        idx    <= '0;
                        is_vol <= 1'b0;
                        state  <= StLoad;
                    end
                end
                StLoad: begin
                    wr_word  <= is_vol ? vol_word(vol_level_q) : init_word(idx);
                    if (is_vol) begin
                        vol_pending <= 1'b0;
                    end
                    retry    <= '0;
                    retrying <= 1'b0;
                    state    <= StIssue;
                end
                StIssue: begin
                    wr_go <= 1'b1;
                    state <= StWait;
                end
                StWait: begin
                    if (wr_done) begin
                        ack_q <= wr_ack;
                        state <= StCheck;
                    end
                end
                StCheck: begin
                    wr_go <= 1'b0;
                    if (ack_q == 3'b111) begin
                        retrying <= 1'b0;
                        state    <= StGap;
                    end else if (retry < MaxRetry) begin
                        retry    <= retry + RetryW'(1);
                        retrying <= 1'b1;
                        state    <= StGap;
                    end else begin
                        error     <= 1'b1;
                        err_index <= is_vol ? 4'hF : idx;
                        busy      <= 1'b0;
                        state     <= StError;
                    end
                end
                StGap: begin
                    if (timer_zero) begin
                        if (retrying) begin
                            state <= StIssue;
                        end else if (!is_vol && idx != LastIdx) begin
                            idx   <= idx + 4'd1;
                            state <= StLoad;
                        end else begin
                            if (!is_vol) begin
                                config_done <= 1'b1;
                            end
                            if (vol_pending) begin
                                is_vol <= 1'b1;
                                state  <= StLoad;
                            end else begin
                                busy  <= 1'b0;
                                state <= StDone;
                            end
                        end
                    end
                end
                StDone: begin
                    if (start) begin
                        // Rerunning the table: config is no longer known-good
                        config_done <= 1'b0;
                        state       <= StPwrup;
                    end else if (vol_pending) begin
                        is_vol <= 1'b1;
                        state  <= StLoad;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                StError: begin
                    if (start) begin
                        error       <= 1'b0;
                        config_done <= 1'b0;
                        state       <= StPwrup;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                default: state <= StPwrup;
            endcase
            // Placed last so a new request beats the pending-clear in StLoad
            if (vol_req) begin
                vol_pending <= 1'b1;
                vol_level_q <= vol_level;
            end
        end
    end

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Self-checking bench: randomized writer model (latency, NACK codes, volume
// levels) against a queue-based model of the expected word stream.
module tb_codec_config_sequencer;

    localparam int unsigned P  = 20;
    localparam int unsigned G  = 5;
    localparam int unsigned MR = 3;
    localparam int unsigned NR = 11;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        vol_req;
    logic [6:0]  vol_level;
    logic [15:0] wr_word;
    logic        wr_go;
    logic        wr_done;
    logic [2:0]  wr_ack;
    logic        busy;
    logic        config_done;
    logic        error;
    logic [3:0]  err_index;

    codec_config_sequencer #(
        .CLK_HZ         (50_000_000),
        .POWERUP_CYCLES (P),
        .GAP_CYCLES     (G),
        .MAX_RETRY      (MR),
        .NUM_REGS       (NR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .vol_req     (vol_req),
        .vol_level   (vol_level),
        .wr_word     (wr_word),
        .wr_go       (wr_go),
        .wr_done     (wr_done),
        .wr_ack      (wr_ack),
        .busy        (busy),
        .config_done (config_done),
        .error       (error),
        .err_index   (err_index)
    );

    always #5 clk = ~clk;

    logic [15:0] table_words [NR] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
                                      16'h0812, 16'h0A00, 16'h0C00, 16'h0E42, 16'h1000,
                                      16'h1201};

    int          checks = 0;
    int          passes = 0;
    int          fails  = 0;
    int          nack_plan [NR];
    int          nack_left [NR];
    logic [15:0] issued [$];
    logic [15:0] expq [$];
    int          proto_err = 0;
    int          go_pulses = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int table_index(input logic [15:0] w);
        for (int i = 0; i < NR; i++) begin
            if (table_words[i] === w) return i;
        end
        return -1;
    endfunction

    // Writer model: random latency, NACKs table words per nack_left
    initial begin
        int cnt;
        int lat;
        int ti;
        wr_done = 1'b0;
        wr_ack  = 3'b000;
        cnt     = 0;
        lat     = 0;
        forever begin
            @(negedge clk);
            if (wr_go !== 1'b1) begin
                wr_done = 1'b0;
                wr_ack  = 3'b000;
                cnt     = 0;
                lat     = $urandom_range(0, 3);
            end else if (!wr_done) begin
                if (cnt >= lat) begin
                    ti = table_index(wr_word);
                    if (ti >= 0 && nack_left[ti] > 0) begin
                        nack_left[ti]--;
                        wr_ack = 3'($urandom_range(0, 6));
                    end else begin
                        wr_ack = 3'b111;
                    end
                    wr_done = 1'b1;
                    issued.push_back(wr_word);
                end else begin
                    cnt++;
                end
            end
        end
    end

    // Protocol monitor: word stability, gap length, busy during writes
    initial begin
        int          low_run;
        logic        prev_go;
        logic [15:0] prev_word;
        low_run   = 1000;
        prev_go   = 1'b0;
        prev_word = '0;
        forever begin
            @(negedge clk);
            if (wr_go === 1'b1) begin
                if (prev_go && wr_word !== prev_word) proto_err++;
                if (!prev_go) begin
                    go_pulses++;
                    if (low_run < G) proto_err++;
                end
                if (busy !== 1'b1) proto_err++;
                low_run = 0;
            end else begin
                if (prev_go && reset === 1'b1 && wr_word !== prev_word) proto_err++;
                low_run++;
            end
            prev_go   = (wr_go === 1'b1);
            prev_word = wr_word;
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_vol(input logic [6:0] lvl);
        vol_req   = 1'b1;
        vol_level = lvl;
        @(negedge clk);
        vol_req = 1'b0;
    endtask

    task automatic set_plan(input int i, input int n);
        nack_plan[i] = n;
        nack_left[i] = n;
    endtask

    task automatic clear_plan();
        for (int i = 0; i < NR; i++) set_plan(i, 0);
    endtask

    task automatic run_to_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b1 && n < 10) begin
            tick(1);
            n++;
        end
        check({tag, " busy rise"}, busy, 1);
        n = 0;
        while (busy !== 1'b0 && n < 5000) begin
            tick(1);
            n++;
        end
        check({tag, " idle"}, busy, 0);
    endtask

    // Expected word stream: each table word issued once plus one per NACK,
    // capped at MR+1 attempts, which ends the run with an error
    task automatic build_exp(input bit with_vol, input logic [6:0] lvl, output int err_idx);
        expq.delete();
        err_idx = -1;
        for (int i = 0; i < NR; i++) begin
            int n;
            n = (nack_plan[i] > int'(MR)) ? int'(MR) + 1 : nack_plan[i] + 1;
            for (int k = 0; k < n; k++) expq.push_back(table_words[i]);
            if (nack_plan[i] > int'(MR)) begin
                err_idx = i;
                break;
            end
        end
        if (with_vol && err_idx < 0) expq.push_back({7'h02, 1'b1, 1'b0, lvl});
    endtask

    task automatic compare_run(input string tag);
        check({tag, " count"}, issued.size(), expq.size());
        for (int i = 0; i < expq.size() && i < issued.size(); i++) begin
            check($sformatf("%s word%0d", tag, i), issued[i], expq[i]);
        end
        check({tag, " protocol"}, proto_err, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " wr_go"}, wr_go, 0);
        check({tag, " wr_word"}, wr_word, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " config_done"}, config_done, 0);
        check({tag, " error"}, error, 0);
        check({tag, " err_index"}, err_index, 0);
    endtask

    initial begin
        int          n;
        int          e;
        int          r;
        int          snap;
        logic [6:0]  lvl;

        reset     = 1'b0;
        start     = 1'b0;
        vol_req   = 1'b0;
        vol_level = '0;
        clear_plan();
        tick(3);
        check_reset_outputs("reset");

        // All words ACKed on first attempt
        issued.delete();
        reset = 1'b1;
        n = 0;
        while (wr_go !== 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        check("first go", wr_go, 1);
        check("powerup delay", (n >= int'(P)), 1);
        run_to_idle("init");
        build_exp(1'b0, 7'h00, e);
        compare_run("init");
        check("init config_done", config_done, 1);
        check("init error", error, 0);

        // idx 3 NACKed twice, plus a random recoverable NACK count elsewhere
        clear_plan();
        set_plan(3, 2);
        r = $urandom_range(0, NR - 1);
        if (r != 3) set_plan(r, $urandom_range(0, MR));
        issued.delete();
        pulse_start();
        run_to_idle("retry");
        build_exp(1'b0, 7'h00, e);
        compare_run("retry");
        check("retry config_done", config_done, 1);
        check("retry error", error, 0);

        // idx 5 never ACKs: retries exhausted
        clear_plan();
        set_plan(5, 100);
        issued.delete();
        pulse_start();
        run_to_idle("fail");
        build_exp(1'b0, 7'h00, e);
        compare_run("fail");
        check("fail error", error, 1);
        check("fail err_index", err_index, e);
        check("fail config_done", config_done, 0);
        snap = go_pulses;
        tick(40);
        check("fail no more go", go_pulses, snap);
        check("fail held error", error, 1);

        // start from ERROR reruns the table and clears error
        clear_plan();
        issued.delete();
        pulse_start();
        check("rerun error cleared", error, 0);
        run_to_idle("rerun");
        build_exp(1'b0, 7'h00, e);
        compare_run("rerun");
        check("rerun config_done", config_done, 1);

        // Two volume requests during init: only the last level is written
        issued.delete();
        pulse_start();
        tick(3);
        pulse_vol(7'h50);
        tick(2);
        pulse_vol(7'h79);
        run_to_idle("vol init");
        build_exp(1'b1, 7'h79, e);
        compare_run("vol init");
        check("vol init config_done", config_done, 1);

        // Volume writes from DONE; start during the write is ignored
        for (int it = 0; it < 3; it++) begin
            lvl = (it == 0) ? 7'h30 : 7'($urandom);
            issued.delete();
            pulse_vol(lvl);
            n = 0;
            while (wr_go !== 1'b1 && n < 20) begin
                tick(1);
                n++;
            end
            check($sformatf("vol%0d go", it), wr_go, 1);
            check($sformatf("vol%0d busy", it), busy, 1);
            pulse_start();
            run_to_idle($sformatf("vol%0d", it));
            expq.delete();
            expq.push_back({7'h02, 1'b1, 1'b0, lvl});
            compare_run($sformatf("vol%0d", it));
            check($sformatf("vol%0d config_done", it), config_done, 1);
        end

        // Reset while waiting on the writer
        pulse_start();
        n = 0;
        while (wr_go !== 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        check("midreset go seen", wr_go, 1);
        reset = 1'b0;
        tick(1);
        check_reset_outputs("midreset");
        tick(2);
        issued.delete();
        reset = 1'b1;
        run_to_idle("after reset");
        build_exp(1'b0, 7'h00, e);
        compare_run("after reset");
        check("after reset config_done", config_done, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/codec_config_sequencer.md
Name: codec_config_sequencer

Overview:
- Sequences the audio codec's I2C word writer: walks a fixed table of 16-bit codec register words, then services runtime headphone-volume writes.
- Each word is {reg_addr[6:0], reg_data[8:0]}.
- Sits between the top-level control/UI logic and the I2C word writer; it is the only master of that writer.
- Handles power-up delay, per-word handshake, ACK checking with bounded retry, inter-word gap and error reporting.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency; informational, used only to derive the defaults below.
- POWERUP_CYCLES, 50_000, idle cycles after reset before the first write (1 ms).
- GAP_CYCLES, 2_000, cycles with wr_go low between consecutive writes.
- MAX_RETRY, 3, extra attempts per word after a NACK.
- NUM_REGS, 11, number of entries in the init table.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low
- start  in  1  pulse: rerun full init table; ignored while busy
- vol_req  in  1  pulse: request headphone volume write
- vol_level  in  7  volume code, sampled with vol_req
- wr_word  out  16  word presented to the writer; stable while wr_go=1
- wr_go  out  1  level; writer runs while high and resets while low
- wr_done  in  1  level; writer finished current word
- wr_ack  in  3  per-byte ACK flags (1 = ACKed), valid when wr_done=1
- busy  out  1  sequencer not in IDLE/DONE/ERROR
- config_done  out  1  init table completed with all ACKs
- error  out  1  a word exhausted its retries
- err_index  out  4  table index of the failing word; 4'hF for a volume word

Behaviour:
- Reset (reset=0 at a clk edge), all outputs 0:
  - wr_word=0, wr_go=0, busy=0, config_done=0, error=0, err_index=0.
  - Pending volume cleared; state goes to PWRUP.
  - Reset mid-transfer drops wr_go the same edge.
- States:
  - PWRUP: count POWERUP_CYCLES, then LOAD with idx=0.
  - LOAD: wr_word<=table[idx] or the volume word; retry count=0; go to ISSUE.
  - ISSUE: wr_go<=1; go to WAIT.
  - WAIT: hold wr_go until wr_done=1 is seen on a clock edge; then capture wr_ack and go to CHECK.
  - CHECK: wr_go<=0.
    - If wr_ack==3'b111, go to GAP with success.
    - Else if retry<MAX_RETRY, retry++ and go to GAP, then reissue the same word.
    - Else set error=1 and err_index, go to ERROR.
  - GAP: wr_go stays low for GAP_CYCLES. Then:
    - If retrying, go to ISSUE.
    - Else if more table entries remain, idx++ and go to LOAD.
    - Else if table just finished, set config_done=1.
    - Then, if a volume write is pending, go to LOAD with the volume word; otherwise go to DONE.
  - DONE: if a volume write is pending, go to LOAD with the volume word; start=1 goes to PWRUP.
  - ERROR: hold error; start=1 clears error and config_done and goes to PWRUP. vol_req is latched but not serviced until re-init completes.
  - IDLE is not used after reset; PWRUP is entered directly.
- Volume word: {7'h02, 1'b1 (both channels), 1'b0 (no zero-cross), vol_level}.
  - vol_req sets pending and latches the level in any state.
  - A later vol_req before service overwrites the level; only the last value is written.
  - vol_req and a pending-clear in the same cycle: the new request wins and stays pending.
- Volume writes only start after config_done=1. A pending request during init is serviced right after the last table word.
- start while busy=1 is ignored; start coincident with vol_req: both are honoured, table first.
- busy=1 in PWRUP, LOAD, ISSUE, WAIT, CHECK, GAP.
- wr_go falls at least one cycle before wr_word changes. wr_word never changes while wr_go=1.
- Counters:
  - Gap/power-up counter is sized $clog2(max(POWERUP_CYCLES, GAP_CYCLES))+1.
  - Retry counter is $clog2(MAX_RETRY+1) bits.
  - idx is 4 bits; NUM_REGS ≤ 15.

Decomposition:
- Package codec_cfg_pkg holds:
  - state enum;
  - codec register address constants (R_LLINE=0, R_RLINE=1, R_LHP=2, R_RHP=3, R_APATH=4, R_DPATH=5, R_PWR=6, R_IFACE=7, R_SRATE=8, R_ACTIVE=9, R_RESET=15);
  - init table function: 1E00, 0017, 0217, 0479, 0679, 0812, 0A00, 0C00, 0E42, 1000, 1201 (hex).
- One sub-module, codec_cfg_timer: loadable down-counter with a zero flag, shared by PWRUP and GAP.

Test Plan:
- Reset, then a writer model that ACKs all bytes (POWERUP_CYCLES=20, GAP_CYCLES=5) → 11 wr_go pulses carrying 1E00…1201 in order; config_done=1; busy=0; error=0.
- Writer NACKs word idx 3 (wr_ack=3'b101) twice, then ACKs → 0479 issued 3 times; sequence completes; config_done=1.
- Writer always NACKs idx 5 → 0812 issued MAX_RETRY+1=4 times; error=1, err_index=5, config_done=0; no further wr_go. Then start → rerun from 1E00, and error clears.
- vol_req with level 7'h50 during init, then vol_req with 7'h79 → after 1201, exactly one extra write of 0579; nothing for 0550.
- After DONE, vol_req with 7'h30 → one write of 0530 with busy=1 during it; start during that write is ignored.
- reset=0 while in WAIT → next edge wr_go=0, all outputs 0; after release, the sequence restarts from PWRUP and word 1E00.
